// File: rtl/qram_request_sequencer.sv
// Request sequencer for the QRAM-in-SDRAM cell: serializes address/data,
// strobes Write/Read, and deserializes outputQBit into a response word.
module qram_request_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic              DDRClock,
    input  logic              ResetN,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqData,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [DATA_W-1:0] RspData,
    output logic              AddressQBit,
    output logic              inputQBit,
    output logic              Write,
    output logic              Read,
    input  logic              outputQBit
);

    localparam int M1   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int MAXV = (M1 > READ_LAT) ? M1 : READ_LAT;
    localparam int CW   = $clog2(MAXV + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, WRITE, READ_WAIT, READ, RESP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_sr;
    logic [DATA_W-1:0] data_sr;
    logic              is_write;
    logic [CW-1:0]     cnt;
    logic              last;

    assign last = (cnt == '0);

    always_ff @(posedge DDRClock or negedge ResetN) begin
        if (!ResetN) begin
            state       <= IDLE;
            addr_sr     <= '0;
            data_sr     <= '0;
            is_write    <= 1'b0;
            cnt         <= '0;
            ReqReady    <= 1'b0;
            RspValid    <= 1'b0;
            RspData     <= '0;
            AddressQBit <= 1'b0;
            inputQBit   <= 1'b0;
            Write       <= 1'b0;
            Read        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ReqValid && ReqReady) begin
                        state       <= ADDR;
                        ReqReady    <= 1'b0;
                        AddressQBit <= ReqAddr[ADDR_W-1];
                        addr_sr     <= ReqAddr << 1;
                        data_sr     <= ReqData;
                        is_write    <= ReqWrite;
                        cnt         <= CW'(ADDR_W - 1);
                    end else begin
                        ReqReady <= 1'b1;
                    end
                end
                ADDR: begin
                    if (last) begin
                        AddressQBit <= 1'b0;
                        if (is_write) begin
                            state     <= WRITE;
                            Write     <= 1'b1;
                            inputQBit <= data_sr[DATA_W-1];
                            data_sr   <= data_sr << 1;
                            cnt       <= CW'(DATA_W - 1);
                        end else if (READ_LAT > 0) begin
                            state <= READ_WAIT;
                            Read  <= 1'b1;
                            cnt   <= CW'(READ_LAT - 1);
                        end else begin
                            state <= READ;
                            Read  <= 1'b1;
                            cnt   <= CW'(DATA_W - 1);
                        end
                    end else begin
                        AddressQBit <= addr_sr[ADDR_W-1];
                        addr_sr     <= addr_sr << 1;
                        cnt         <= cnt - CW'(1);
                    end
                end
                WRITE: begin
                    if (last) begin
                        state     <= IDLE;
                        Write     <= 1'b0;
                        inputQBit <= 1'b0;
                        ReqReady  <= 1'b1;
                    end else begin
                        inputQBit <= data_sr[DATA_W-1];
                        data_sr   <= data_sr << 1;
                        cnt       <= cnt - CW'(1);
                    end
                end
                READ_WAIT: begin
                    if (last) begin
                        state <= READ;
                        cnt   <= CW'(DATA_W - 1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                READ: begin
                    // first sampled bit walks up to the MSB
                    data_sr <= {data_sr[DATA_W-2:0], outputQBit};
                    if (last) begin
                        state    <= RESP;
                        Read     <= 1'b0;
                        RspValid <= 1'b1;
                        RspData  <= {data_sr[DATA_W-2:0], outputQBit};
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (RspReady) begin
                        state    <= IDLE;
                        RspValid <= 1'b0;
                        ReqReady <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
